// File: rtl/traffic_pkg.sv
// Shared indices and default timing constants for the traffic controller and its
// sensor front end.
package traffic_pkg;

  // Sensor bit positions in raw_sensors / traffic_sensors
  localparam int NS1 = 0;
  localparam int NS2 = 1;
  localparam int EW1 = 2;
  localparam int EW2 = 3;

  // Lamp bit positions in light
  localparam int NS_G = 0;
  localparam int NS_Y = 1;
  localparam int EW_G = 2;
  localparam int EW_Y = 3;

  // Emergency channel position in the debug vector
  localparam int EMERG_DBG = 4;

  localparam int N_SENSORS = 4;
  localparam int N_CHAN    = N_SENSORS + 1;

  localparam int DEFAULT_DEBOUNCE_CYCLES   = 4;
  localparam int DEFAULT_EMERG_HOLD_CYCLES = 30;
  localparam int DEFAULT_CNT_W             = 8;

  typedef logic [N_SENSORS-1:0] sensor_vec_t;
  typedef logic [N_CHAN-1:0]    chan_vec_t;

endpackage

// File: rtl/sensor_debounce.sv
// One input channel: 2-flop synchroniser followed by a consecutive-sample debouncer.
// rise/fall flag the edge on which d is about to change.
module sensor_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic d,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // Stage p0/p1: metastability guard on the asynchronous input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // A new level is accepted once it has differed from d for DEBOUNCE_CYCLES edges
  assign accept = (sync_p1 != d) && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      d   <= 1'b0;
    end else if (sync_p1 == d) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
      d   <= sync_p1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign rise = accept & sync_p1;
  assign fall = accept & ~sync_p1;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions loop-detector and emergency inputs for Traffic_Controller.
// Define SENSOR_LATCH_EN to hold sensor demand until the matching green is seen.
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int EMERG_HOLD_CYCLES = DEFAULT_EMERG_HOLD_CYCLES,
  parameter int CNT_W             = DEFAULT_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  raw_sensors,
  input  logic        raw_emergency,
  input  logic [3:0]  light,
  output logic [3:0]  traffic_sensors,
  output logic        emergency,
  output logic [4:0]  debounced
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(EMERG_HOLD_CYCLES);

  chan_vec_t        raw_all;
  chan_vec_t        d;
  chan_vec_t        rise;
  chan_vec_t        fall;
  logic [CNT_W-1:0] hold_cnt;

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  assign raw_all = {raw_emergency, raw_sensors};

  for (genvar i = 0; i < N_CHAN; i++) begin : g_chan
    sensor_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_all[i]),
      .d     (d[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  assign debounced = d;

  // Emergency stretch: reload on release, cancel on a fresh request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (rise[EMERG_DBG]) begin
      hold_cnt <= '0;
    end else if (fall[EMERG_DBG]) begin
      hold_cnt <= HOLD_LOAD;
    end else begin
      hold_cnt <= sat_dec(hold_cnt);
    end
  end

  assign emergency = d[EMERG_DBG] | (hold_cnt != '0);

`ifdef SENSOR_LATCH_EN
  sensor_vec_t latch;
  sensor_vec_t served;
  logic        unused_latch_inputs;

  assign served = {{2{light[EW_G]}}, {2{light[NS_G]}}};

  // A rising demand wins over a coincident clear; the green clears it next edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch <= '0;
    end else begin
      latch <= rise[N_SENSORS-1:0] | (latch & ~served);
    end
  end

  assign traffic_sensors     = d[N_SENSORS-1:0] | latch;
  assign unused_latch_inputs = light[NS_Y] ^ light[EW_Y] ^ (^fall[N_SENSORS-1:0]);
`else
  logic unused_latch_inputs;

  assign traffic_sensors     = d[N_SENSORS-1:0];
  assign unused_latch_inputs = (^light) ^ (^rise[N_SENSORS-1:0]) ^ (^fall[N_SENSORS-1:0]);
`endif

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Self-checking bench for traffic_sensor_conditioner: vector table, directed corner
// sequences and randomized stimulus against a window-based reference model.
module tb_traffic_sensor_conditioner;
  import traffic_pkg::*;

  localparam int DEB  = DEFAULT_DEBOUNCE_CYCLES;
  localparam int HOLD = DEFAULT_EMERG_HOLD_CYCLES;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] raw_sensors = 4'b0;
  logic       raw_emergency = 1'b0;
  logic [3:0] light = 4'b0;
  logic [3:0] traffic_sensors;
  logic       emergency;
  logic [4:0] debounced;

  traffic_sensor_conditioner #(
    .DEBOUNCE_CYCLES   (DEB),
    .EMERG_HOLD_CYCLES (HOLD),
    .CNT_W             (DEFAULT_CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .raw_sensors     (raw_sensors),
    .raw_emergency   (raw_emergency),
    .light           (light),
    .traffic_sensors (traffic_sensors),
    .emergency       (emergency),
    .debounced       (debounced)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a channel flips once its last DEB synchronised samples all
  // disagree with the current debounced level; samples lag the raw pins by 2 edges.
  logic [4:0] rawq[$];
  logic [4:0] md;
  logic [3:0] mlatch;
  int         last_fall;

  task automatic model_reset();
    rawq.delete();
    md        = '0;
    mlatch    = '0;
    last_fall = -1000000;
  endtask

  task automatic model_edge();
    logic [4:0] prev;
    logic [4:0] rising;
    int         n;
    rawq.push_back({raw_emergency, raw_sensors});
    n    = rawq.size();
    prev = md;
    for (int c = 0; c < 5; c++) begin
      bit all_opp = 1'b1;
      for (int j = 0; j < DEB; j++) begin
        int  idx = n - 3 - j;
        logic v  = (idx >= 0) ? rawq[idx][c] : 1'b0;
        if (v == prev[c]) all_opp = 1'b0;
      end
      if (all_opp) md[c] = ~prev[c];
    end
    rising = md & ~prev;
    for (int i = 0; i < 4; i++) begin
      if (rising[i]) mlatch[i] = 1'b1;
      else if ((i < 2) ? light[0] : light[2]) mlatch[i] = 1'b0;
    end
    if (prev[4] && !md[4]) last_fall = n;
  endtask

  function automatic logic [3:0] model_ts();
`ifdef SENSOR_LATCH_EN
    return md[3:0] | mlatch;
`else
    return md[3:0];
`endif
  endfunction

  function automatic logic model_em();
    return md[4] || ((rawq.size() - last_fall) < HOLD);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wait_em_release(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      chk({tag, "_em_before_release"}, emergency, 1);
      if (!debounced[4]) seen = 1'b1;
    end
    chk({tag, "_deb_em_fell"}, seen, 1);
  endtask

  task automatic check_hold(input string tag);
    for (int k = 1; k < HOLD; k++) begin
      tick();
      chk({tag, "_em_held"}, emergency, 1);
    end
    tick();
    chk({tag, "_em_dropped"}, emergency, 0);
  endtask

  typedef struct {
    logic [3:0] rs;
    logic       re;
    logic [3:0] lt;
    int         cyc;
    logic [3:0] ets;
    logic       eem;
    logic [4:0] edeb;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Both greens on so a latched build tracks d within one edge
    vecs[0] = '{4'b0001, 1'b0, 4'b0101, 10, 4'b0001, 1'b0, 5'b00001};
    vecs[1] = '{4'b0011, 1'b0, 4'b0101, 10, 4'b0011, 1'b0, 5'b00011};
    vecs[2] = '{4'b1100, 1'b0, 4'b0101, 10, 4'b1100, 1'b0, 5'b01100};
    vecs[3] = '{4'b1111, 1'b1, 4'b0101, 10, 4'b1111, 1'b1, 5'b11111};
    vecs[4] = '{4'b0000, 1'b0, 4'b0101, 10, 4'b0000, 1'b1, 5'b00000};
    vecs[5] = '{4'b0000, 1'b0, 4'b0101, 30, 4'b0000, 1'b0, 5'b00000};
    vecs[6] = '{4'b1010, 1'b0, 4'b0101, 10, 4'b1010, 1'b0, 5'b01010};
    vecs[7] = '{4'b0101, 1'b0, 4'b0101,  3, 4'b1010, 1'b0, 5'b01010};
    vecs[8] = '{4'b0101, 1'b0, 4'b0101, 10, 4'b0101, 1'b0, 5'b00101};
    vecs[9] = '{4'b0000, 1'b0, 4'b0101, 10, 4'b0000, 1'b0, 5'b00000};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ts", traffic_sensors, 0);
    chk("reset_em", emergency, 0);
    chk("reset_deb", debounced, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Pass-through latency
    light = 4'b0101;
    raw_sensors = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("pass_deb0_edge%0d", k), debounced[0], (k == 6));
      chk($sformatf("pass_ts0_edge%0d", k), traffic_sensors[0], (k == 6));
    end
    raw_sensors = 4'b0000;
    repeat (10) tick();

    // Glitch of 3 cycles
    raw_sensors = 4'b0100;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) raw_sensors = 4'b0000;
      tick();
      chk("glitch_deb2", debounced[2], 0);
      chk("glitch_ts2", traffic_sensors[2], 0);
    end

    // Demand latch hold and clear
    light = 4'b0001;
    raw_sensors = 4'b1000;
    repeat (10) tick();
    raw_sensors = 4'b0000;
    repeat (12) tick();
    chk("latch_deb3_low", debounced[3], 0);
`ifdef SENSOR_LATCH_EN
    chk("latch_ts3_held", traffic_sensors[3], 1);
    light = 4'b0100;
    tick();
    chk("latch_ts3_cleared", traffic_sensors[3], 0);
`else
    chk("nolatch_ts3_follows_d", traffic_sensors[3], 0);
`endif
    light = 4'b0101;
    repeat (4) tick();

    // Vector table
    for (int i = 0; i < 10; i++) begin
      raw_sensors   = vecs[i].rs;
      raw_emergency = vecs[i].re;
      light         = vecs[i].lt;
      repeat (vecs[i].cyc) tick();
      chk($sformatf("vec%0d_ts", i), traffic_sensors, vecs[i].ets);
      chk($sformatf("vec%0d_em", i), emergency, vecs[i].eem);
      chk($sformatf("vec%0d_deb", i), debounced, vecs[i].edeb);
    end

    // Emergency stretch
    raw_emergency = 1'b1;
    repeat (20) tick();
    chk("stretch_deb4_high", debounced[4], 1);
    raw_emergency = 1'b0;
    wait_em_release("stretch");
    check_hold("stretch");

    // Re-trigger inside the hold window
    raw_emergency = 1'b1;
    repeat (20) tick();
    raw_emergency = 1'b0;
    wait_em_release("retrig_first");
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("retrig_em_in_hold", emergency, 1);
    end
    raw_emergency = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("retrig_em_second", emergency, 1);
    end
    raw_emergency = 1'b0;
    wait_em_release("retrig_second");
    check_hold("retrig");

    // Asynchronous reset in the middle of a hold
    raw_sensors   = 4'b0011;
    raw_emergency = 1'b1;
    repeat (20) tick();
    raw_emergency = 1'b0;
    wait_em_release("rst");
    repeat (5) tick();
    chk("rst_em_before", emergency, 1);
    chk("rst_ts_before", traffic_sensors, 4'b0011);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_async_em", emergency, 0);
    chk("rst_async_ts", traffic_sensors, 0);
    chk("rst_async_deb", debounced, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held_em", emergency, 0);
    @(negedge clk);
    raw_sensors = 4'b0000;
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("rst_after_em", emergency, 0);
      chk("rst_after_ts", traffic_sensors, 0);
      chk("rst_after_deb", debounced, 0);
    end

    // Randomized run against the reference model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [3:0] rs = raw_sensors;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) rs[b] = ~rs[b];
      raw_sensors = rs;
      if ($urandom_range(0, 24) == 0) raw_emergency = ~raw_emergency;
      if (cyc % 8 == 0) light = 4'($urandom_range(0, 15));
      tick();
      chk("rand_deb", debounced, md);
      chk("rand_ts", traffic_sensors, model_ts());
      chk("rand_em", emergency, model_em());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_sensor_conditioner.md
# traffic_sensor_conditioner

Front-end stage that feeds `Traffic_Controller`. It takes the raw, asynchronous loop-detector inputs and emergency-request input. It synchronises and debounces them, then latches vehicle demand until the requesting direction has been served. It also stretches the emergency request to a minimum hold time. Its `traffic_sensors` and `emergency` outputs drive the controller's inputs of the same names, and the controller's `light` output is fed back here to clear latched demand.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronised cycles a new input level must hold before it is accepted. Legal range is 1..255.
- `EMERG_HOLD_CYCLES`, default 30: extra cycles `emergency` stays high after the debounced request falls. Legal range is 0..255.
- `CNT_W`, default 8: width of the debounce and hold counters.
- `clk`, input, 1: single clock.
- `reset`, input, 1: asynchronous reset, active high.
- `raw_sensors`, input, 4: unsynchronised loop detectors. Bit [3] is EW2, [2] is EW1, [1] is NS2, [0] is NS1.
- `raw_emergency`, input, 1: unsynchronised emergency-vehicle request.
- `light`, input, 4: controller lamp state. Bit [3] is EW_Y, [2] is EW_G, [1] is NS_Y, [0] is NS_G.
- `traffic_sensors`, output, 4: conditioned demand, same bit map as `raw_sensors`.
- `emergency`, output, 1: conditioned, stretched emergency request.
- `debounced`, output, 5: debug view. Bits [3:0] are the debounced sensors and [4] is the debounced emergency.

## Operation
- **Synchroniser:** each of the 5 raw inputs passes through a 2-flop synchroniser, producing `s`.
- **Debouncer (per channel):**
  - Each channel holds a stable register `d` and a counter `cnt`.
  - If `s == d`, then `cnt <= 0`.
  - Otherwise `cnt <= cnt + 1`. When `cnt == DEBOUNCE_CYCLES-1`, the channel sets `d <= s` and `cnt <= 0`.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles therefore never reaches `d`.
- **Demand latch (sensor bits only, `SENSOR_LATCH_EN`):**
  - `latch[i]` is set on the edge where `d[i]` rises.
  - NS bits [1:0] are cleared on any edge where `light[0]` (NS_G) is 1.
  - EW bits [3:2] are cleared on any edge where `light[2]` (EW_G) is 1.
  - When set and clear coincide, set wins. The bit then clears on the next edge if the green is still on.
- **Sensor output:** `traffic_sensors[i] = d[i] | latch[i]`, combinational from registers only.
- **Emergency stretch:**
  - On the edge where `d_em` falls, `hold_cnt <= EMERG_HOLD_CYCLES`.
  - While nonzero, `hold_cnt` decrements by 1 per cycle.
  - A rising `d_em` forces `hold_cnt <= 0`.
  - `emergency = d_em | (hold_cnt != 0)`.
- **Reset values:** all counters, `s`, `d`, `latch`, `hold_cnt`, `traffic_sensors`, `emergency` and `debounced` are 0.
- **Reset during operation:** a reset mid-debounce or mid-hold immediately drops every output to 0 with no stretch.

## Timing
- **Stable input:** a raw level held stable from sampling edge k appears on `debounced`, `traffic_sensors` and `emergency` after edge k+2+DEBOUNCE_CYCLES. This is total latency DEBOUNCE_CYCLES+2.
- **Emergency stretch:** `emergency` falls exactly EMERG_HOLD_CYCLES cycles after `d_em` falls. With EMERG_HOLD_CYCLES=0 it falls on the same edge as `d_em`.
- **Latch clear:** a latched bit takes effect one edge after the first edge where the matching green is sampled high.
- **Counter behaviour:** counters never wrap. `cnt` resets on acceptance or on a match, and `hold_cnt` saturates at 0.
- **Both greens high:** if `light[0]` and `light[2]` are both 1 (illegal from the controller), both latch groups clear. No error is flagged.

## Configuration
- `SENSOR_LATCH_EN` defined: the demand latch is present as described.
- `SENSOR_LATCH_EN` undefined:
  - No latch registers are built.
  - `traffic_sensors = d[3:0]`.
  - `light` is unused.
  - Emergency logic is unchanged.

## Structure
- **Package `traffic_pkg`:**
  - Sensor bit indices: NS1=0, NS2=1, EW1=2, EW2=3.
  - Light bit indices: NS_G=0, NS_Y=1, EW_G=2, EW_Y=3.
  - Debug index EMERG_DBG=4.
  - Default cycle constants. The controller also uses these.
- **Sub-module `sensor_debounce`:**
  - Contents: synchroniser, `cnt` and `d` for one channel.
  - Parameters: `DEBOUNCE_CYCLES` and `CNT_W`.
  - Outputs: `d` plus a one-cycle `rise` and `fall` pulse.
  - Instantiated 5 times.

## Test plan
- **Debounce pass-through:** DEBOUNCE_CYCLES=4, `raw_sensors[0]` goes 0->1 and holds. `traffic_sensors[0]` rises exactly 6 edges later, and `debounced[0]` matches.
- **Glitch rejection:** `raw_sensors[2]` pulses high for 3 cycles. `debounced[2]` and `traffic_sensors[2]` stay 0 throughout.
- **Demand latch hold and clear** (`SENSOR_LATCH_EN`):
  - `raw_sensors[3]` high for 10 cycles, then 0, with `light`=4'b0001. `traffic_sensors[3]` stays 1.
  - Then `light`=4'b0100. `traffic_sensors[3]` is 0 one edge later.
- **Emergency stretch:** EMERG_HOLD_CYCLES=30, `raw_emergency` high for 20 cycles then low. `emergency` stays high for 30 cycles after `debounced[4]` falls, then goes to 0.
- **Re-trigger:** during the hold window, `raw_emergency` rises again for 8 cycles. `emergency` never drops, and the hold restarts from 30 after the second fall.
- **Reset mid-hold:** assert `reset` asynchronously 5 cycles into the hold. `emergency`, `traffic_sensors` and `debounced` are 0 before the next clock edge and remain 0 after release until new stable input.
